// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the main control decoder.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        KIND_LW  = 3'd0,
        KIND_SW  = 3'd1,
        KIND_R   = 3'd2,
        KIND_BEQ = 3'd3,
        KIND_I   = 3'd4,
        KIND_JAL = 3'd5
    } kind_e;

    // Codes match the decoder's imm_src field.
    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_packer.sv
// Places a signed immediate into its RV32I bit positions and reports whether it is encodable.
module imm_packer
    import rv_isa_pkg::*;
(
    input  logic [31:0] imm,
    input  imm_fmt_e    fmt,
    output logic [31:0] bits,
    output logic        range_ok
);

    // An immediate fits when every bit above the field's sign bit copies it.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (imm[31:11] == {21{imm[11]}});
    assign fits_13 = (imm[31:12] == {20{imm[12]}});
    assign fits_21 = (imm[31:20] == {12{imm[20]}});

    always_comb begin
        bits     = '0;
        range_ok = 1'b0;
        unique case (fmt)
            FMT_I: begin
                bits     = {imm[11:0], 20'b0};
                range_ok = fits_12;
            end
            FMT_S: begin
                bits     = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                range_ok = fits_12;
            end
            FMT_B: begin
                bits     = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                range_ok = fits_13 && !imm[0];
            end
            FMT_J: begin
                bits     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                range_ok = fits_21 && !imm[0];
            end
            default: begin
                bits     = '0;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I encoder: S1 holds the raw request fields, S2 the packed word.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int          ERR_CNT_W = 8,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_kind,
    input  logic [2:0]           in_funct3,
    input  logic                 in_funct7_5,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        s1_valid;
    logic [2:0]  s1_kind;
    logic [2:0]  s1_funct3;
    logic        s1_funct7_5;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    logic        s1_load;
    logic        s2_load;
    imm_fmt_e    fmt;
    logic [31:0] imm_bits;
    logic        range_ok;
    logic        is_shift;
    logic        legal;
    logic [31:0] enc_word;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_kind     <= '0;
            s1_funct3   <= '0;
            s1_funct7_5 <= 1'b0;
            s1_rd       <= '0;
            s1_rs1      <= '0;
            s1_rs2      <= '0;
            s1_imm      <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_kind     <= in_kind;
                s1_funct3   <= in_funct3;
                s1_funct7_5 <= in_funct7_5;
                s1_rd       <= in_rd;
                s1_rs1      <= in_rs1;
                s1_rs2      <= in_rs2;
                s1_imm      <= in_imm;
            end
        end
    end

    always_comb begin
        fmt = FMT_I;
        case (s1_kind)
            KIND_SW:  fmt = FMT_S;
            KIND_BEQ: fmt = FMT_B;
            KIND_JAL: fmt = FMT_J;
            default:  fmt = FMT_I;
        endcase
    end

    imm_packer u_imm_packer (
        .imm      (s1_imm),
        .fmt      (fmt),
        .bits     (imm_bits),
        .range_ok (range_ok)
    );

    assign is_shift = (s1_funct3 == F3_SLL) || (s1_funct3 == F3_SRX);

    // Shift immediates reuse the rs2 slot, so they bypass the I-format packing.
    always_comb begin
        enc_word = '0;
        legal    = 1'b0;
        case (s1_kind)
            KIND_LW: begin
                enc_word = imm_bits | {12'b0, s1_rs1, F3_W, s1_rd, OP_LOAD};
                legal    = range_ok;
            end
            KIND_SW: begin
                enc_word = imm_bits | {7'b0, s1_rs2, s1_rs1, F3_W, 5'b0, OP_STORE};
                legal    = range_ok;
            end
            KIND_R: begin
                enc_word = {1'b0, s1_funct7_5, 5'b0, s1_rs2, s1_rs1, s1_funct3, s1_rd, OP_OP};
                legal    = 1'b1;
            end
            KIND_BEQ: begin
                enc_word = imm_bits | {7'b0, s1_rs2, s1_rs1, F3_BEQ, 5'b0, OP_BRANCH};
                legal    = range_ok;
            end
            KIND_I: begin
                if (is_shift) begin
                    enc_word = {1'b0, s1_funct7_5, 5'b0, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, OP_IMM};
                    legal    = (s1_imm[31:5] == 27'b0) && !((s1_funct3 == F3_SLL) && s1_funct7_5);
                end else begin
                    enc_word = imm_bits | {12'b0, s1_rs1, s1_funct3, s1_rd, OP_IMM};
                    legal    = range_ok;
                end
            end
            KIND_JAL: begin
                enc_word = imm_bits | {20'b0, s1_rd, OP_JAL};
                legal    = range_ok;
            end
            default: begin
                enc_word = '0;
                legal    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= legal ? enc_word : NOP_WORD;
                out_err  <= !legal;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the main control decoder. It accepts a field-level instruction description (kind, registers, funct bits, immediate) over a valid/ready handshake and emits the packed 32-bit instruction word. The opcode and immediate layouts are exactly those the decoder path consumes. It is used by the boot/test program injector and by decoder verification to generate legal instruction streams. It is a 2-stage pipeline with full backpressure, immediate range checking and an error counter.

Parameters:
ERR_CNT_W, 8, width of saturating error counter
NOP_WORD, 32'h0000_0013, word emitted in place of an illegal request (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request this cycle
in_kind  in  3  instruction kind (package enum)
in_funct3  in  3  funct3 for R/I kinds; ignored otherwise
in_funct7_5  in  1  instr bit 30 (sub/sra/srai); R and I-shift only
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate / byte offset
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts word
out_inst  out  32  encoded instruction
out_err  out  1  request was illegal; out_inst = NOP_WORD
err_count  out  ERR_CNT_W  saturating count of illegal requests delivered

Behaviour:
- Reset (async, rstn=0): both stage valids, out_valid=0, out_inst=0, out_err=0, err_count=0; in_ready=1 after release. Takes effect immediately, mid-transfer included; in-flight requests are dropped.
- Handshake: transfer occurs when valid&&ready at the rising edge. out_inst/out_err stay stable while out_valid&&!out_ready. No combinational path from in_* to out_*.
- Pipeline: S1 registers the raw fields. S2 registers the encoded word. Latency is 2 cycles from input accept to out_valid. Throughput is 1/cycle.
- Stall rules: S2 loads when !out_valid||out_ready. S1 loads when !s1_valid||S2 loads. in_ready = !s1_valid || !out_valid || out_ready.
- Kinds and encoding (opcode; funct3):
  - LW=0: 0000011; 010. I-imm.
  - SW=1: 0100011; 010. S-imm; rd ignored.
  - R=2: 0110011; in_funct3. bit30=in_funct7_5; other funct7 bits 0; imm ignored.
  - BEQ=3: 1100011; 000. B-imm; rd ignored.
  - I=4: 0010011; in_funct3. I-imm. For funct3 001/101: inst[31:25]={0,funct7_5,00000}, inst[24:20]=imm[4:0].
  - JAL=5: 1101111. J-imm; rs1/rs2 ignored.
  - Fields: rd at [11:7], rs1 at [19:15], rs2 at [24:20].
- Immediate packing:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Illegal, giving out_err=1 and out_inst=NOP_WORD:
  - kind 6/7
  - LW/SW/I imm outside [-2048,2047]
  - I-shift imm outside [0,31]
  - I-shift with funct3=001 and funct7_5=1
  - BEQ imm outside [-4096,4094] or odd
  - JAL imm outside [-1048576,1048574] or odd
  - Range is checked on the full 32-bit signed in_imm.
- err_count increments on each out_valid&&out_ready&&out_err and saturates at all-ones without wrapping.
- Legal words always have out_err=0.

Decomposition:
- Package rv_isa_pkg:
  - kind enum (LW, SW, R, BEQ, I, JAL)
  - opcode constants (OP_LOAD, OP_STORE, OP_OP, OP_BRANCH, OP_IMM, OP_JAL)
  - funct3 constants (F3_W=010, F3_BEQ=000)
  - imm-format enum (I, S, B, J), matching the decoder's imm_src codes 00/01/10/11
  - Both encoder and decoder import it.
- Sub-module imm_packer (combinational): in imm, fmt → out packed bits plus range_ok flag. Instantiated between S1 and S2.

Test Plan:
- Single requests, out_ready=1, each appearing 2 cycles after accept:
  - I addi rd=1 rs1=0 imm=5 → 0x00500093
  - LW rd=2 rs1=1 imm=8 → 0x0080A103
  - SW rs1=1 rs2=2 imm=4 → 0x0020A223
- R-type, rd=3 rs1=1 rs2=2 funct3=000:
  - funct7_5=0 → 0x002081B3
  - funct7_5=1 → 0x402081B3
- Control flow:
  - BEQ rs1=1 rs2=2 imm=-4 → 0xFE208EE3
  - JAL rd=1 imm=8 → 0x008000EF
- Illegal requests, each giving out_inst=0x00000013, out_err=1; err_count goes 0→3:
  - I imm=2048
  - BEQ imm=3
  - kind=7
- Backpressure: 4 back-to-back requests with out_ready=0 for 4 cycles → in_ready=0 after 2 accepted and out_inst held stable; with out_ready=1, all 4 emitted in order, no loss or duplication.
- Reset: assert rstn=0 while out_valid=1 → out_valid and err_count go 0 without a clock edge; after release, first new request emerges with latency 2.
